// File: rtl/chan_merge.sv
// rtl/chan_merge.sv - two-channel valid/ready merge into one registered, source-tagged output
module chan_merge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   grant;
  logic   any_valid;
  logic   load;

  // State register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration, load decision, readies and next state. Readies are gated by
  // rst_n so nothing is accepted while reset is held.
  always_comb begin
    state_nxt = state;
    any_valid = in0_valid | in1_valid;
    grant     = 1'b0;
    load      = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;

    if (in0_valid && in1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = in1_valid;
    end

    load      = rst_n && any_valid && ((state == EMPTY) || out_ready);
    in0_ready = load && !grant;
    in1_ready = load && grant;

    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (out_ready && !any_valid) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  // Output word, its source tag and the round-robin pointer move only on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_sel    <= 1'b0;
      last_grant <= 1'b1;
    end else if (load) begin
      out_data   <= grant ? in1_data : in0_data;
      out_sel    <= grant;
      last_grant <= grant;
    end
  end

  // Per-channel acceptance counters, free-running wrap at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (in0_valid && in0_ready) cnt0 <= cnt0 + 8'd1;
      if (in1_valid && in1_ready) cnt1 <= cnt1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_chan_merge.sv
// tb/tb_chan_merge.sv - self-checking bench for chan_merge
module tb_chan_merge;

  logic       clk;
  logic       rst_n;
  logic       in0_valid;
  logic [7:0] in0_data;
  logic       in0_ready;
  logic       in1_valid;
  logic [7:0] in1_data;
  logic       in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sel;
  logic       out_ready;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int n_checks = 0;
  int n_errors = 0;

  chan_merge #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "is a word held, what is it, who went last, how many taken".
  bit       m_full;
  bit [7:0] m_data;
  bit       m_sel;
  bit       m_last;
  int       m_cnt0;
  int       m_cnt1;

  // Every falling edge: compare DUT against the model, then advance the model
  // by what the coming rising edge must do given the (stable) inputs.
  always @(negedge clk) begin
    bit acc;
    bit g;
    if (!rst_n) begin
      m_full = 0; m_data = 0; m_sel = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      check("rst_in0_ready", in0_ready, 0);
      check("rst_in1_ready", in1_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_cnt0", cnt0, 0);
      check("rst_cnt1", cnt1, 0);
    end else begin
      acc = (in0_valid || in1_valid) && (!m_full || out_ready);
      if (in0_valid && in1_valid) g = !m_last;
      else g = in1_valid;
      check("in0_ready", in0_ready, acc && !g);
      check("in1_ready", in1_ready, acc && g);
      check("out_valid", out_valid, m_full);
      if (m_full) begin
        check("out_data", out_data, m_data);
        check("out_sel", out_sel, m_sel);
      end
      check("cnt0", cnt0, m_cnt0 % 256);
      check("cnt1", cnt1, m_cnt1 % 256);
      if (acc) begin
        m_full = 1;
        m_data = g ? in1_data : in0_data;
        m_sel  = g;
        m_last = g;
        if (g) m_cnt1++;
        else m_cnt0++;
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input bit [7:0] d0, input bit v1, input bit [7:0] d1, input bit ordy);
    in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 8'hEE, 1, 8'hDD, 1);
    tick();
    #1;
    check("lit_reset_ready0", in0_ready, 0);
    check("lit_reset_ready1", in1_ready, 0);
    check("lit_reset_out_valid", out_valid, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b1;
    tick();

    // Single word from channel 0.
    drive(1, 8'hA5, 0, 0, 1);
    #1;
    check("lit_single_ready0", in0_ready, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    #1;
    check("lit_single_valid", out_valid, 1);
    check("lit_single_data", out_data, 8'hA5);
    check("lit_single_sel", out_sel, 0);
    check("lit_single_cnt0", cnt0, 1);
    // Drain.
    tick();
    #1;
    check("lit_drain_valid", out_valid, 0);

    // Backpressure: hold 0x3C while channel 1 waits.
    drive(1, 8'h3C, 0, 0, 1);
    tick();
    drive(0, 0, 1, 8'h5A, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("lit_bp_ready0", in0_ready, 0);
      check("lit_bp_ready1", in1_ready, 0);
      check("lit_bp_data", out_data, 8'h3C);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("lit_bp_release_ready1", in1_ready, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    #1;
    check("lit_bp_next_data", out_data, 8'h5A);
    check("lit_bp_next_sel", out_sel, 1);
    tick();

    // Mid-operation reset while holding 0x77.
    drive(1, 8'h77, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("lit_mid_held", out_data, 8'h77);
    rst_n = 1'b0;
    #1;
    check("lit_mid_valid", out_valid, 0);
    check("lit_mid_cnt0", cnt0, 0);
    check("lit_mid_cnt1", cnt1, 0);
    drive(1, 8'h11, 1, 8'h22, 1);
    tick();
    rst_n = 1'b1;
    #1;
    check("lit_mid_first_ready0", in0_ready, 1);
    check("lit_mid_first_ready1", in1_ready, 0);

    // Contention: strict alternation starting with channel 0, one per clock.
    for (int i = 0; i < 6; i++) begin
      tick();
      check("lit_cont_valid", out_valid, 1);
      check("lit_cont_data", out_data, (i % 2 == 0) ? 8'h11 : 8'h22);
      check("lit_cont_sel", out_sel, i % 2);
      check("lit_cont_balance", ((cnt0 > cnt1) ? cnt0 - cnt1 : cnt1 - cnt0) <= 1, 1);
    end
    drive(0, 0, 0, 0, 1);
    tick();

    // Counter wrap on channel 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1, 8'h00, 1);
    for (int i = 0; i < 256; i++) begin
      in1_data = 8'(i);
      tick();
      if (i == 254) check("lit_wrap_255", cnt1, 255);
    end
    drive(0, 0, 0, 0, 1);
    #1;
    check("lit_wrap_cnt1", cnt1, 0);
    check("lit_wrap_cnt0", cnt0, 0);
    check("lit_wrap_last", out_data, 8'hFF);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
